// File: rtl/point_config_if.sv
// Configuration/geometry bundle between the stage sequencer and its neighbours.
// With POINT_CONFIG_DONE_EN defined the bundle also carries o_done.
interface point_config_if;
   logic [2:0] i_point_configuration;
   logic       i_working;
   logic       o_new_stage_trigger;
   logic [9:0] o_calcs_per_group;
   logic [7:0] o_stride_index_offset;
   logic [9:0] o_stride;
   logic [7:0] o_group_offset;
`ifdef POINT_CONFIG_DONE_EN
   logic       o_done;
`endif

   modport master (
      output i_point_configuration, i_working,
      input  o_new_stage_trigger, o_calcs_per_group, o_stride_index_offset,
             o_stride, o_group_offset
`ifdef POINT_CONFIG_DONE_EN
      , input o_done
`endif
   );

   modport slave (
      input  i_point_configuration, i_working,
      output o_new_stage_trigger, o_calcs_per_group, o_stride_index_offset,
             o_stride, o_group_offset
`ifdef POINT_CONFIG_DONE_EN
      , output o_done
`endif
   );
endinterface

// File: rtl/point_config.sv
// Stage/group/butterfly sequencer for a radix-2 transform of N = 4 << cfg points.
// Optional o_done output is enabled with POINT_CONFIG_DONE_EN.
module point_config #(
   parameter int unsigned DELAY = 6
) (
   input  logic          clk,
   input  logic          i_resetn,
   point_config_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [7:0] DRAIN_LAST = 8'((DELAY > 0) ? DELAY - 1 : 0);

   state_t     state_q, state_d;
   logic [2:0] cfg_q, cfg_d;
   logic [3:0] stage_q, stage_d;
   logic [7:0] cnt_q, cnt_d;
   logic [9:0] stride_q, stride_d;
   logic [9:0] calcs_q, calcs_d;
   logic [7:0] j_q, j_d;
   logic [7:0] g_q, g_d;
   logic       trig_q, trig_d;
   logic       advance;
   logic       last_j;
   logic       last_g;
   logic [8:0] groups_m1;

   assign groups_m1 = (9'd1 << stage_q) - 9'd1;
   assign last_j    = ({2'b00, j_q} == (calcs_q - 10'd1));
   assign last_g    = ({1'b0, g_q} == groups_m1);

   always_comb begin
      state_d  = state_q;
      cfg_d    = cfg_q;
      stage_d  = stage_q;
      cnt_d    = cnt_q;
      stride_d = stride_q;
      calcs_d  = calcs_q;
      j_d      = j_q;
      g_d      = g_q;
      trig_d   = 1'b0;
      advance  = 1'b0;

      if (!bus.i_working) begin
         state_d  = IDLE;
         cfg_d    = '0;
         stage_d  = '0;
         cnt_d    = '0;
         stride_d = '0;
         calcs_d  = '0;
         j_d      = '0;
         g_d      = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cfg_d    = bus.i_point_configuration;
               stage_d  = '0;
               cnt_d    = '0;
               stride_d = 10'd4 << bus.i_point_configuration;
               calcs_d  = 10'd2 << bus.i_point_configuration;
               j_d      = '0;
               g_d      = '0;
               state_d  = RUN;
            end
            RUN: begin
               if (last_j) begin
                  j_d = '0;
                  if (last_g) begin
                     if (DELAY == 0) begin
                        advance = 1'b1;
                     end else begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                     end
                  end else begin
                     g_d = g_q + 8'd1;
                  end
               end else begin
                  j_d = j_q + 8'd1;
               end
            end
            DRAIN: begin
               if (cnt_q == DRAIN_LAST) advance = 1'b1;
               else                     cnt_d   = cnt_q + 8'd1;
            end
            DONE: begin
               j_d = '0;
               g_d = '0;
            end
            default: state_d = IDLE;
         endcase

         // Last stage index is S-1 = cfg+1; the final pulse marks completion, not a new stage.
         if (advance) begin
            trig_d = 1'b1;
            cnt_d  = '0;
            j_d    = '0;
            g_d    = '0;
            if (stage_q < ({1'b0, cfg_q} + 4'd1)) begin
               stage_d  = stage_q + 4'd1;
               stride_d = stride_q >> 1;
               calcs_d  = calcs_q >> 1;
               state_d  = RUN;
            end else begin
               state_d = DONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q  <= IDLE;
         cfg_q    <= '0;
         stage_q  <= '0;
         cnt_q    <= '0;
         stride_q <= '0;
         calcs_q  <= '0;
         j_q      <= '0;
         g_q      <= '0;
         trig_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cfg_q    <= cfg_d;
         stage_q  <= stage_d;
         cnt_q    <= cnt_d;
         stride_q <= stride_d;
         calcs_q  <= calcs_d;
         j_q      <= j_d;
         g_q      <= g_d;
         trig_q   <= trig_d;
      end
   end

   assign bus.o_new_stage_trigger   = trig_q;
   assign bus.o_calcs_per_group     = calcs_q;
   assign bus.o_stride_index_offset = j_q;
   assign bus.o_stride              = stride_q;
   assign bus.o_group_offset        = g_q;

`ifdef POINT_CONFIG_DONE_EN
   logic done_q, done_d;

   assign done_d = (state_d == DONE);

   always_ff @(posedge clk or negedge i_resetn) begin
      if (!i_resetn) done_q <= 1'b0;
      else           done_q <= done_d;
   end

   assign bus.o_done = done_q;
`endif

endmodule

// File: tb/tb_point_config.sv
// Directed bench for point_config with DELAY = 6; expected values are hand-derived.
module tb_point_config;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   point_config_if bus ();

   point_config #(.DELAY(6)) dut (
      .clk      (clk),
      .i_resetn (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic chk_geom(input string tag, input int trig, input int stride,
                           input int calcs, input int g, input int j);
      chk({tag, ".trig"},   32'(bus.o_new_stage_trigger),   32'(trig));
      chk({tag, ".stride"}, 32'(bus.o_stride),              32'(stride));
      chk({tag, ".calcs"},  32'(bus.o_calcs_per_group),     32'(calcs));
      chk({tag, ".g"},      32'(bus.o_group_offset),        32'(g));
      chk({tag, ".j"},      32'(bus.o_stride_index_offset), 32'(j));
   endtask

   initial begin
      int ntrig, last_trig, err0, err_t, err_l, trig_seen;
      passed = 0;
      total  = 0;

      // 1. reset held
      rst_n = 1'b0;
      bus.i_point_configuration = 3'd0;
      bus.i_working = 1'b0;
      trig_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.o_new_stage_trigger !== 1'b0) trig_seen++;
      end
      chk_geom("reset", 0, 0, 0, 0, 0);
      chk("reset.no_trig", 32'(trig_seen), 32'd0);

      // 2. cfg=0 run; cfg changed to 7 mid-run must be ignored
      rst_n = 1'b1;
      tick();
      chk_geom("idle", 0, 0, 0, 0, 0);
      bus.i_working = 1'b1;
      tick();                                   // edge 0
      chk_geom("c0.e0", 0, 4, 2, 0, 0);
      bus.i_point_configuration = 3'd7;
      tick();                                   // edge 1
      chk_geom("c0.e1", 0, 4, 2, 0, 1);
      tick();                                   // edge 2: drain begins
      chk_geom("c0.e2", 0, 4, 2, 0, 0);
      trig_seen = 0;
      for (int e = 3; e < 8; e++) begin
         tick();
         if (bus.o_new_stage_trigger !== 1'b0) trig_seen++;
      end
      chk("c0.drain_no_trig", 32'(trig_seen), 32'd0);
      tick();                                   // edge 8
      chk_geom("c0.e8", 1, 2, 1, 0, 0);
      tick();                                   // edge 9
      chk_geom("c0.e9", 0, 2, 1, 1, 0);
      trig_seen = 0;
      for (int e = 10; e < 16; e++) begin
         tick();
         if (bus.o_new_stage_trigger !== 1'b0) trig_seen++;
      end
      chk("c0.s1_no_trig", 32'(trig_seen), 32'd0);
      tick();                                   // edge 16: completion pulse
      chk_geom("c0.e16", 1, 2, 1, 0, 0);
      tick();
      chk_geom("c0.done", 0, 2, 1, 0, 0);
`ifdef POINT_CONFIG_DONE_EN
      chk("c0.o_done", 32'(bus.o_done), 32'd1);
`endif
      for (int i = 0; i < 5; i++) tick();
      chk_geom("c0.done_hold", 0, 2, 1, 0, 0);

      // 3. abort mid stage 1, then restart
      bus.i_working = 1'b0;
      bus.i_point_configuration = 3'd0;
      tick();
      chk_geom("abort0", 0, 0, 0, 0, 0);
`ifdef POINT_CONFIG_DONE_EN
      chk("abort0.o_done", 32'(bus.o_done), 32'd0);
`endif
      bus.i_working = 1'b1;
      for (int e = 0; e <= 9; e++) tick();     // edge 9: stage 1, g=1
      chk_geom("s1.e9", 0, 2, 1, 1, 0);
      bus.i_working = 1'b0;
      tick();
      chk_geom("abort1", 0, 0, 0, 0, 0);
      bus.i_working = 1'b1;
      tick();
      chk_geom("restart", 0, 4, 2, 0, 0);
      bus.i_working = 1'b0;
      tick();

      // 4. cfg=7 full run
      bus.i_point_configuration = 3'd7;
      bus.i_working = 1'b1;
      ntrig = 0; last_trig = -1; err0 = 0; err_t = 0; err_l = 0;
      for (int c = 0; c < 2400; c++) begin
         tick();
         if (c == 0) chk_geom("c7.e0", 0, 512, 256, 0, 0);
         if (c < 256 && (bus.o_group_offset !== 8'd0 ||
                         bus.o_stride_index_offset !== 8'(c))) err0++;
         if (bus.o_new_stage_trigger === 1'b1) begin
            ntrig++;
            last_trig = c;
            if (c != 262 * ntrig) err_t++;
         end
         if (c >= 2096 && c < 2096 + 256 &&
             (bus.o_group_offset !== 8'(c - 2096) || bus.o_stride !== 10'd2 ||
              bus.o_calcs_per_group !== 10'd1 || bus.o_stride_index_offset !== 8'd0)) err_l++;
      end
      chk("c7.stage0_seq_err", 32'(err0), 32'd0);
      chk("c7.trig_period_err", 32'(err_t), 32'd0);
      chk("c7.trig_count", 32'(ntrig), 32'd9);
      chk("c7.last_trig_cycle", 32'(last_trig), 32'd2358);
      chk("c7.last_stage_err", 32'(err_l), 32'd0);
      chk_geom("c7.done", 0, 2, 1, 0, 0);
`ifdef POINT_CONFIG_DONE_EN
      chk("c7.o_done", 32'(bus.o_done), 32'd1);
`endif

      // 6. async reset during drain of cfg=0
      bus.i_working = 1'b0;
      bus.i_point_configuration = 3'd0;
      tick();
      bus.i_working = 1'b1;
      for (int e = 0; e <= 4; e++) tick();     // edge 4: in DRAIN
      chk_geom("drain", 0, 4, 2, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      chk_geom("async_rst", 0, 0, 0, 0, 0);
      bus.i_working = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk_geom("post_rst", 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
